i2s_mic_tx: RTL and testbench



---
 rtl/i2s_mic_tx.sv | 155 +++++++++++++++
 tb/tb_i2s_mic_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_tx.sv
// INMP441-compatible I2S slave transmitter: FIFO-fed samples shifted MSB-first in the selected slot.
// Optional feature: define I2S_MIC_TX_UNDERRUN_HOLD_EN to repeat the last sample on underrun (zeros otherwise).
module i2s_mic_tx #(
   parameter int W_DATA = 24,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sck,
   input  logic                    ws,
   input  logic                    right,
   input  logic                    in_valid,
   input  logic [W_DATA-1:0]       in_data,
   output logic                    in_ready,
   output logic                    sd,
   output logic                    sd_oe,
   output logic                    underrun,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(W_DATA + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(W_DATA);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t              state, state_nx;
   logic                sck_s1, sck_s2, sck_d;
   logic                ws_s1, ws_s2, ws_cur, armed;
   logic                rise_p, fall_p, slot_start, own_start;
   logic                load, push, pop;
   logic [W_DATA-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [W_DATA-1:0]   shreg, fill;
   logic [CW-1:0]       bitcnt;

   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_s1 <= 1'b0;
         sck_s2 <= 1'b0;
         sck_d  <= 1'b0;
         ws_s1  <= 1'b0;
         ws_s2  <= 1'b0;
         ws_cur <= 1'b0;
         armed  <= 1'b0;
      end else begin
         sck_s1 <= sck;
         sck_s2 <= sck_s1;
         sck_d  <= sck_s2;
         ws_s1  <= ws;
         ws_s2  <= ws_s1;
         if (rise_p) begin
            ws_cur <= ws_s2;
            armed  <= 1'b1;
         end
      end
   end

   // The first rise only arms, so a reset-time sync edge can never fake a slot start.
   assign rise_p     = sck_s2 & ~sck_d;
   assign fall_p     = ~sck_s2 & sck_d;
   assign slot_start = rise_p & armed & (ws_s2 != ws_cur);
   assign own_start  = slot_start & (ws_s2 == right);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: defaulting every combinational output first keeps the block free of inferred latches.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (own_start) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT: begin
            if (slot_start)                         state_nx = own_start ? LOAD : IDLE;
            else if (fall_p && bitcnt == LAST_BIT)  state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load     = (state == LOAD);
      pop      = load && (level != '0);
      underrun = load && (level == '0);
   end

   assign in_ready = (level != FULL_LVL);
   assign push     = in_valid & in_ready;

   // NOTE: the sample array carries no reset; pointers and level alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

`ifdef I2S_MIC_TX_UNDERRUN_HOLD_EN
   logic [W_DATA-1:0] last_sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   last_sample <= '0;
      else if (pop) last_sample <= mem[rd_ptr];
   end

   assign fill = last_sample;
`else
   assign fill = '0;
`endif

   // sd changes only on fall_p so it is stable for the master's next sck rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg  <= '0;
         bitcnt <= '0;
         sd     <= 1'b0;
         sd_oe  <= 1'b0;
      end else if (load) begin
         shreg  <= pop ? mem[rd_ptr] : fill;
         bitcnt <= '0;
      end else if (state == SHIFT && slot_start) begin
         sd    <= 1'b0;
         sd_oe <= 1'b0;
      end else if (state == SHIFT && fall_p) begin
         if (bitcnt == LAST_BIT) begin
            sd    <= 1'b0;
            sd_oe <= 1'b0;
         end else begin
            sd     <= shreg[W_DATA-1];
            sd_oe  <= 1'b1;
            shreg  <= {shreg[W_DATA-2:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_mic_tx.sv
// Directed bench for i2s_mic_tx: acts as the SCK/WS master and reassembles slot bits.
module tb_i2s_mic_tx;

   localparam int W = 24;
   localparam int D = 4;
   localparam logic [31:0] FULL_MASK = 32'h01FF_FFFE;

`ifdef I2S_MIC_TX_UNDERRUN_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sck = 1'b1;
   logic         ws = 1'b1;
   logic         right = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready, sd, sd_oe, underrun;
   logic [2:0]   level;

   int           n_tests = 0;
   int           n_fail  = 0;

   logic [W-1:0] rx;
   logic [31:0]  oe_mask;
   int           ur_cnt, stray, drop_clk;
   logic [W-1:0] exp_fill;

   i2s_mic_tx #(.W_DATA(W), .DEPTH(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck      (sck),
      .ws       (ws),
      .right    (right),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .sd       (sd),
      .sd_oe    (sd_oe),
      .underrun (underrun),
      .level    (level)
   );

   always #10 clk = ~clk;   // 50 MHz; sck half period = 8 clk (3.125 MHz)

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One slot of n_sck bit clocks; ws changes with the first falling edge.
   // rx collects bits seen at rises 1..W, oe_mask[k] is sd_oe just before rise k.
   task automatic run_slot(input logic wsv, input int n_sck);
      logic track;
      rx = '0; oe_mask = '0; ur_cnt = 0; stray = 0; drop_clk = 0; track = 1'b0;
      @(negedge clk);
      for (int k = 0; k < n_sck; k++) begin
         sck = 1'b0;
         if (k == 0) ws = wsv;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (underrun) ur_cnt++;
         end
         oe_mask[k] = sd_oe;
         if (k == 0) track = sd_oe;
         if (sd_oe && k >= 1 && k <= W) rx[W-k] = sd;
         if (!sd_oe && sd) stray++;
         sck = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (underrun) ur_cnt++;
            if (k == 0 && track && drop_clk == 0 && !sd_oe) drop_clk = c + 1;
         end
      end
   endtask

   task automatic push_sample(input logic [W-1:0] d);
      int budget = 100;
      @(negedge clk);
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_tests++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL push_ready: in_ready stayed 0, sample %h not accepted", d);
      end else begin
         in_valid = 1'b1;
         in_data  = d;
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (sd !== 1'b0)       begin n_fail++; $display("FAIL reset_sd: got %b want 0", sd); end
      n_tests++; if (sd_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sd_oe: got %b want 0", sd_oe); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      n_tests++; if (level !== 3'd0)    begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_left_slot();
      right = 1'b0;
      push_sample(24'hA5C3F1);
      run_slot(1'b1, 32);
      n_tests++; if (oe_mask !== 32'h0) begin n_fail++; $display("FAIL left_warmup_oe: got %h want 0", oe_mask); end
      run_slot(1'b0, 32);
      n_tests++; if (rx !== 24'hA5C3F1)      begin n_fail++; $display("FAIL left_data: got %h want a5c3f1", rx); end
      n_tests++; if (oe_mask !== FULL_MASK)  begin n_fail++; $display("FAIL left_oe_mask: got %h want %h", oe_mask, FULL_MASK); end
      n_tests++; if (ur_cnt !== 0)           begin n_fail++; $display("FAIL left_underrun: got %0d want 0", ur_cnt); end
      run_slot(1'b1, 32);
      n_tests++; if (oe_mask !== 32'h0)      begin n_fail++; $display("FAIL left_right_slot_oe: got %h want 0", oe_mask); end
      n_tests++; if (stray !== 0)            begin n_fail++; $display("FAIL left_sd_released: got %0d stray ones want 0", stray); end
      n_tests++; if (level !== 3'd0)         begin n_fail++; $display("FAIL left_level: got %0d want 0", level); end
   endtask

   task automatic test_right_channel();
      right = 1'b1;
      push_sample(24'h800001);
      push_sample(24'h7FFFFF);
      n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL right_level_2: got %0d want 2", level); end
      run_slot(1'b0, 32);
      n_tests++; if (oe_mask !== 32'h0) begin n_fail++; $display("FAIL right_left_slot_oe: got %h want 0", oe_mask); end
      run_slot(1'b1, 32);
      n_tests++; if (rx !== 24'h800001)     begin n_fail++; $display("FAIL right_data_0: got %h want 800001", rx); end
      n_tests++; if (oe_mask !== FULL_MASK) begin n_fail++; $display("FAIL right_oe_0: got %h want %h", oe_mask, FULL_MASK); end
      n_tests++; if (level !== 3'd1)        begin n_fail++; $display("FAIL right_level_1: got %0d want 1", level); end
      n_tests++; if (ur_cnt !== 0)          begin n_fail++; $display("FAIL right_underrun_0: got %0d want 0", ur_cnt); end
      run_slot(1'b0, 32);
      run_slot(1'b1, 32);
      n_tests++; if (rx !== 24'h7FFFFF)     begin n_fail++; $display("FAIL right_data_1: got %h want 7fffff", rx); end
      n_tests++; if (level !== 3'd0)        begin n_fail++; $display("FAIL right_level_0: got %0d want 0", level); end
      n_tests++; if (ur_cnt !== 0)          begin n_fail++; $display("FAIL right_underrun_1: got %0d want 0", ur_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] samples [4];
      samples[0] = 24'h000001;
      samples[1] = 24'hFFFFFE;
      samples[2] = 24'h00F00F;
      samples[3] = 24'h123456;
      for (int i = 0; i < 4; i++) push_sample(samples[i]);
      n_tests++; if (level !== 3'd4)    begin n_fail++; $display("FAIL full_level: got %0d want 4", level); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      in_valid = 1'b1;
      in_data  = 24'hDEAD00;
      repeat (4) @(negedge clk);
      n_tests++; if (level !== 3'd4)    begin n_fail++; $display("FAIL full_fifth_held: level %0d want 4", level); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_fifth_ready: got %b want 0", in_ready); end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_slot(1'b0, 32);
         run_slot(1'b1, 32);
         n_tests++;
         if (rx !== samples[i]) begin
            n_fail++;
            $display("FAIL drain_data_%0d: got %h want %h", i, rx, samples[i]);
         end
      end
      n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
   endtask

   task automatic test_underrun();
      exp_fill = HOLD ? 24'h123456 : 24'h000000;
      for (int s = 0; s < 2; s++) begin
         run_slot(1'b0, 32);
         run_slot(1'b1, 32);
         n_tests++; if (ur_cnt !== 1)         begin n_fail++; $display("FAIL underrun_count_%0d: got %0d want 1", s, ur_cnt); end
         n_tests++; if (rx !== exp_fill)      begin n_fail++; $display("FAIL underrun_data_%0d: got %h want %h", s, rx, exp_fill); end
         n_tests++; if (oe_mask !== FULL_MASK) begin n_fail++; $display("FAIL underrun_oe_%0d: got %h want %h", s, oe_mask, FULL_MASK); end
      end
      n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL underrun_level: got %0d want 0", level); end
   endtask

   task automatic test_short_slot();
      push_sample(24'hC0FFEE);
      push_sample(24'h5A5A5A);
      run_slot(1'b0, 32);
      run_slot(1'b1, 10);
      n_tests++; if (oe_mask !== 32'h0000_03FE) begin n_fail++; $display("FAIL short_partial_oe: got %h want 000003fe", oe_mask); end
      n_tests++; if (rx[W-1:W-9] !== 9'h181)    begin n_fail++; $display("FAIL short_partial_bits: got %h want 181", rx[W-1:W-9]); end
      run_slot(1'b0, 32);
      n_tests++; if (oe_mask !== 32'h1) begin n_fail++; $display("FAIL short_abort_oe: got %h want 00000001", oe_mask); end
      n_tests++;
      if (drop_clk < 1 || drop_clk > 4) begin
         n_fail++;
         $display("FAIL short_abort_latency: got %0d clk want 1..4", drop_clk);
      end
      n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL short_level: got %0d want 1", level); end
      run_slot(1'b1, 32);
      n_tests++; if (rx !== 24'h5A5A5A)     begin n_fail++; $display("FAIL short_next_data: got %h want 5a5a5a", rx); end
      n_tests++; if (oe_mask !== FULL_MASK) begin n_fail++; $display("FAIL short_next_oe: got %h want %h", oe_mask, FULL_MASK); end
      n_tests++; if (ur_cnt !== 0)          begin n_fail++; $display("FAIL short_next_underrun: got %0d want 0", ur_cnt); end
   endtask

   task automatic test_reset_mid_slot();
      push_sample(24'h3C3C3C);
      push_sample(24'h0F0F0F);
      run_slot(1'b0, 32);
      run_slot(1'b1, 8);
      n_tests++; if (sd_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_oe: got %b want 1", sd_oe); end
      #3 rst_n = 1'b0;
      #1;
      n_tests++; if (sd_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b want 0", sd_oe); end
      n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL midrst_level: got %0d want 0", level); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      run_slot(1'b1, 32);
      n_tests++; if (oe_mask !== 32'h0) begin n_fail++; $display("FAIL midrst_quiet: got %h want 0", oe_mask); end
      n_tests++; if (ur_cnt !== 0)      begin n_fail++; $display("FAIL midrst_quiet_ur: got %0d want 0", ur_cnt); end
      run_slot(1'b0, 32);
      run_slot(1'b1, 32);
      n_tests++; if (ur_cnt !== 1)          begin n_fail++; $display("FAIL midrst_empty_ur: got %0d want 1", ur_cnt); end
      n_tests++; if (rx !== 24'h000000)     begin n_fail++; $display("FAIL midrst_fill: got %h want 000000", rx); end
      n_tests++; if (oe_mask !== FULL_MASK) begin n_fail++; $display("FAIL midrst_oe_mask: got %h want %h", oe_mask, FULL_MASK); end
   endtask

   initial begin
      test_reset();
      test_left_slot();
      test_right_channel();
      test_back_to_back();
      test_underrun();
      test_short_slot();
      test_reset_mid_slot();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
